cipher_word_packer: RTL and testbench

CIPHER_WORD_PACKER -- requirements
Module: cipher_word_packer

---
 rtl/cipher_word_packer_pkg.sv | 16 +
 rtl/cipher_word_packer_fifo.sv | 53 +++++
 rtl/cipher_word_packer.sv | 120 ++++++++++++
 tb/tb_cipher_word_packer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_word_packer_pkg.sv
// Shared cryptoveril constants for the ciphertext word packer: word/byte/nbytes
// widths and the {nbytes, word} entry layout held by the output FIFO.
package cipher_word_packer_pkg;

   localparam int CV_WORD_W         = 32;
   localparam int CV_BYTE_W         = 8;
   localparam int CV_NBYTES_W       = 3;
   localparam int CV_BYTES_PER_WORD = CV_WORD_W / CV_BYTE_W;
   localparam int CV_CNT_W          = $clog2(CV_BYTES_PER_WORD);

   typedef struct packed {
      logic [CV_NBYTES_W-1:0] nbytes;
      logic [CV_WORD_W-1:0]   word;
   } pack_entry_t;

endpackage

// File: rtl/cipher_word_packer_fifo.sv
// pack_fifo: show-ahead FIFO of {nbytes, word} entries; pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module pack_fifo
   import cipher_word_packer_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  pack_entry_t wr_data,
   input  logic        rd_en,
   output logic        rd_valid,
   output pack_entry_t rd_data,
   output logic        full
);

   localparam int AW = $clog2(DEPTH);

   pack_entry_t     mem [DEPTH];
   logic [AW:0]     wr_ptr_reg;
   logic [AW:0]     rd_ptr_reg;
   logic            empty;

   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign rd_valid = ~empty;
   assign rd_data  = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (rd_en && !empty) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   // Storage has no reset; stale entries are never visible because rd_valid gates them.
   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/cipher_word_packer.sv
// Packs ciphertext bytes little-endian into 32-bit words and queues them in pack_fifo.
// Optional running XOR checksum enabled by defining CRYPTOVERIL_PACK_CHECKSUM_EN.
module cipher_word_packer
   import cipher_word_packer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [CV_BYTE_W-1:0]   data_in,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CV_WORD_W-1:0]   out_word,
   output logic [CV_NBYTES_W-1:0] out_nbytes,
   output logic                   overflow,
   output logic [CV_BYTE_W-1:0]   checksum
);

   logic [CV_CNT_W-1:0]    count_reg;
   logic [CV_CNT_W-1:0]    count_next;
   logic [CV_WORD_W-1:0]   word_reg;
   logic [CV_WORD_W-1:0]   word_next;
   logic [CV_WORD_W-1:0]   merged_word;
   logic [CV_NBYTES_W-1:0] fill_after;
   logic                   word_complete;
   logic                   push_req;

   pack_entry_t            pend_entry_reg;
   logic                   pend_valid_reg;
   logic                   overflow_reg;

   pack_entry_t            head_entry;
   logic                   head_valid;
   logic                   fifo_full;
   logic                   pop_fire;
   logic                   fifo_wr_en;

   // Each lane takes the incoming byte only when the counter points at it.
   generate
      for (genvar gi = 0; gi < CV_BYTES_PER_WORD; gi++) begin : g_lane
         assign merged_word[gi*CV_BYTE_W +: CV_BYTE_W] =
            (in_valid && (count_reg == CV_CNT_W'(gi))) ? data_in
                                                       : word_reg[gi*CV_BYTE_W +: CV_BYTE_W];
      end
   endgenerate

   always_comb begin
      fill_after    = CV_NBYTES_W'(count_reg) + CV_NBYTES_W'(in_valid);
      word_complete = in_valid && (count_reg == CV_CNT_W'(CV_BYTES_PER_WORD - 1));
      push_req      = word_complete || (flush && (fill_after != '0));
      count_next    = fill_after[CV_CNT_W-1:0];
      word_next     = merged_word;
      if (push_req) begin
         count_next = '0;
         word_next  = '0;
      end
   end

   assign pop_fire   = head_valid & out_ready;
   assign fifo_wr_en = pend_valid_reg & (~fifo_full | pop_fire);

   // Completed words are staged one cycle before entering the FIFO; a staged word that
   // meets a full FIFO with no simultaneous pop is dropped and recorded in overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_reg      <= '0;
         word_reg       <= '0;
         pend_valid_reg <= 1'b0;
         pend_entry_reg <= '0;
         overflow_reg   <= 1'b0;
      end else begin
         count_reg             <= count_next;
         word_reg              <= word_next;
         pend_valid_reg        <= push_req;
         pend_entry_reg.word   <= merged_word;
         pend_entry_reg.nbytes <= fill_after;
         if (pend_valid_reg && fifo_full && !pop_fire) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   pack_fifo #(
      .DEPTH    (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (fifo_wr_en),
      .wr_data  (pend_entry_reg),
      .rd_en    (pop_fire),
      .rd_valid (head_valid),
      .rd_data  (head_entry),
      .full     (fifo_full)
   );

   assign out_valid  = head_valid;
   assign out_word   = head_valid ? head_entry.word   : '0;
   assign out_nbytes = head_valid ? head_entry.nbytes : '0;
   assign overflow   = overflow_reg;

`ifdef CRYPTOVERIL_PACK_CHECKSUM_EN
   logic [CV_BYTE_W-1:0] checksum_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         checksum_reg <= '0;
      end else if (in_valid) begin
         checksum_reg <= checksum_reg ^ data_in;
      end
   end

   assign checksum = checksum_reg;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_cipher_word_packer.sv
// Directed self-checking bench for cipher_word_packer (FIFO_DEPTH = 4).
module tb_cipher_word_packer;

`ifdef CRYPTOVERIL_PACK_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_word;
   logic [2:0]  out_nbytes;
   logic        overflow;
   logic [7:0]  checksum;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_a [4];

   cipher_word_packer #(
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .data_in    (data_in),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_word   (out_word),
      .out_nbytes (out_nbytes),
      .overflow   (overflow),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic with_flush);
      in_valid = 1'b1;
      data_in  = b;
      flush    = with_flush;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // Pops four full words, comparing against exp_a in order, then expects an empty FIFO.
   task automatic drain4(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_word"}, out_word, exp_a[i]);
         chk({tag, "_nbytes"}, 32'(out_nbytes), 32'd4);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      chk({tag, "_empty"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_word", out_word, 32'h0);
      chk("rst_nbytes", 32'(out_nbytes), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_checksum", 32'(checksum), 32'd0);
      rst = 1'b1;
      $display("txn reset done");

      // Four consecutive bytes, latency to out_valid is two cycles
      out_ready = 1'b1;
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      chk("full_lat1_valid", 32'(out_valid), 32'd0);
      tick();
      chk("full_lat2_valid", 32'(out_valid), 32'd1);
      chk("full_word", out_word, 32'h44332211);
      chk("full_nbytes", 32'(out_nbytes), 32'd4);
      tick();
      chk("full_popped", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      $display("txn full word 44332211");

      // Partial word then flush, second flush with no bytes
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("flush_valid", 32'(out_valid), 32'd1);
      chk("flush_word", out_word, 32'h0000BBAA);
      chk("flush_nbytes", 32'(out_nbytes), 32'd2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      tick();
      chk("empty_flush_valid", 32'(out_valid), 32'd0);
      $display("txn flush 0000BBAA and empty flush");

      // Five words into a four-deep FIFO with no consumer
      for (int n = 0; n < 16; n++) send_byte(8'(8'h20 + n), 1'b0);
      tick();
      tick();
      chk("ovf_before", 32'(overflow), 32'd0);
      chk("ovf_held_valid", 32'(out_valid), 32'd1);
      chk("ovf_stable_word", out_word, 32'h23222120);
      for (int n = 16; n < 20; n++) send_byte(8'(8'h20 + n), 1'b0);
      tick();
      tick();
      chk("ovf_set", 32'(overflow), 32'd1);
      exp_a[0] = 32'h23222120;
      exp_a[1] = 32'h27262524;
      exp_a[2] = 32'h2B2A2928;
      exp_a[3] = 32'h2F2E2D2C;
      drain4("ovf_drain");
      chk("ovf_sticky", 32'(overflow), 32'd1);
      $display("txn overflow drop of 33323130");

      // Full FIFO, push coincides with a pop
      do_reset();
      chk("rst2_overflow", 32'(overflow), 32'd0);
      for (int n = 0; n < 16; n++) send_byte(8'(8'h40 + n), 1'b0);
      tick();
      tick();
      send_byte(8'h50, 1'b0);
      send_byte(8'h51, 1'b0);
      send_byte(8'h52, 1'b0);
      send_byte(8'h53, 1'b0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      chk("pushpop_overflow", 32'(overflow), 32'd0);
      exp_a[0] = 32'h47464544;
      exp_a[1] = 32'h4B4A4948;
      exp_a[2] = 32'h4F4E4D4C;
      exp_a[3] = 32'h53525150;
      drain4("pushpop_drain");
      $display("txn push+pop on full FIFO");

      // Reset mid-word discards FIFO contents and partial word
      send_byte(8'h61, 1'b1);
      tick();
      chk("b1_word", out_word, 32'h00000061);
      chk("b1_nbytes", 32'(out_nbytes), 32'd1);
      send_byte(8'h62, 1'b0);
      send_byte(8'h63, 1'b0);
      send_byte(8'h64, 1'b0);
      rst = 1'b0;
      in_valid = 1'b1;
      data_in = 8'h99;
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_word", out_word, 32'h0);
      chk("midrst_nbytes", 32'(out_nbytes), 32'd0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      tick();
      chk("postrst_word", out_word, 32'h04030201);
      chk("postrst_nbytes", 32'(out_nbytes), 32'd4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      $display("txn reset mid-word then 04030201");

      // Flush together with the fourth byte, then counter restarts at lane 0
      send_byte(8'h71, 1'b0);
      send_byte(8'h72, 1'b0);
      send_byte(8'h73, 1'b0);
      send_byte(8'h74, 1'b1);
      tick();
      chk("flush4_word", out_word, 32'h74737271);
      chk("flush4_nbytes", 32'(out_nbytes), 32'd4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      send_byte(8'h81, 1'b1);
      tick();
      chk("wrap_word", out_word, 32'h00000081);
      chk("wrap_nbytes", 32'(out_nbytes), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("wrap_popped", 32'(out_valid), 32'd0);
      $display("txn flush with 4th byte 74737271");

      // Checksum
      do_reset();
      chk("cs_reset", 32'(checksum), 32'd0);
      send_byte(8'h0F, 1'b0);
      chk("cs_0f", 32'(checksum), CS_EN ? 32'h0F : 32'h0);
      send_byte(8'hF0, 1'b0);
      chk("cs_ff", 32'(checksum), CS_EN ? 32'hFF : 32'h0);
      send_byte(8'hFF, 1'b0);
      chk("cs_00", 32'(checksum), 32'h0);
      $display("txn checksum bytes 0F F0 FF");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
